// File: rtl/processor_debug_cmd_arbiter.sv
// processor_debug_cmd_arbiter
//   Shares the core debug command port between two debug hosts (M0, M1).
//   Each host may hold one outstanding command. Commands are issued to the
//   core round-robin. A host can lock the core across a multi-command
//   sequence. A hung core response is turned into an error response after
//   P_TIMEOUT cycles (0 disables the timeout).
// Ports
//   iCLOCK, inRESET          clock, async active-low reset
//   iMx_REQ/COMMAND/TARGET/DATA/LOCK   host command inputs (x = 0,1)
//   oMx_BUSY                 host may not issue
//   oMx_VALID/ERROR/DATA     host response (VALID is a one-cycle pulse)
//   oCORE_REQ/COMMAND/TARGET/DATA, iCORE_BUSY   core command handshake
//   iCORE_VALID/ERROR/DATA   core response
//   oLOCK_VALID/OWNER        current lock state
module processor_debug_cmd_arbiter #(
  parameter logic [15:0] P_TIMEOUT = 16'd1024
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iM0_REQ,
  output logic        oM0_BUSY,
  input  logic [3:0]  iM0_COMMAND,
  input  logic [7:0]  iM0_TARGET,
  input  logic [31:0] iM0_DATA,
  input  logic        iM0_LOCK,
  output logic        oM0_VALID,
  output logic        oM0_ERROR,
  output logic [31:0] oM0_DATA,
  input  logic        iM1_REQ,
  output logic        oM1_BUSY,
  input  logic [3:0]  iM1_COMMAND,
  input  logic [7:0]  iM1_TARGET,
  input  logic [31:0] iM1_DATA,
  input  logic        iM1_LOCK,
  output logic        oM1_VALID,
  output logic        oM1_ERROR,
  output logic [31:0] oM1_DATA,
  output logic        oCORE_REQ,
  input  logic        iCORE_BUSY,
  output logic [3:0]  oCORE_COMMAND,
  output logic [7:0]  oCORE_TARGET,
  output logic [31:0] oCORE_DATA,
  input  logic        iCORE_VALID,
  input  logic        iCORE_ERROR,
  input  logic [31:0] iCORE_DATA,
  output logic        oLOCK_VALID,
  output logic        oLOCK_OWNER
);

  typedef struct packed {
    logic [3:0]  command;
    logic [7:0]  target;
    logic [31:0] data;
  } dbg_cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t      state;
  logic [1:0]  pend;
  dbg_cmd_t    host_cmd [2];
  dbg_cmd_t    in_cmd   [2];
  logic [1:0]  req_in, lock_in, busy, elig;
  logic        lock_valid, lock_owner, last_grant, cur;
  dbg_cmd_t    core_cmd;
  logic [15:0] tmo_cnt;
  logic [1:0]  rsp_valid, rsp_error;
  logic [31:0] rsp_data [2];
  logic        grant_host, timeout_hit;

  assign in_cmd[0] = {iM0_COMMAND, iM0_TARGET, iM0_DATA};
  assign in_cmd[1] = {iM1_COMMAND, iM1_TARGET, iM1_DATA};
  assign req_in    = {iM1_REQ, iM0_REQ};
  assign lock_in   = {iM1_LOCK, iM0_LOCK};

  // A host is busy while it has a command outstanding or the other host owns the lock.
  assign busy[0] = pend[0] | (lock_valid &  lock_owner);
  assign busy[1] = pend[1] | (lock_valid & ~lock_owner);
  assign elig[0] = pend[0] & (~lock_valid | ~lock_owner);
  assign elig[1] = pend[1] & (~lock_valid |  lock_owner);

  // On a tie the host that did not win last time goes first.
  assign grant_host  = (elig == 2'b11) ? ~last_grant : elig[1];
  assign timeout_hit = (P_TIMEOUT != 16'd0) && (tmo_cnt == P_TIMEOUT - 16'd1);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state      <= S_IDLE;
      pend       <= '0;
      host_cmd   <= '{default: '0};
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      core_cmd   <= '0;
      tmo_cnt    <= '0;
      rsp_valid  <= '0;
      rsp_error  <= '0;
      rsp_data   <= '{default: '0};
    end else begin
      rsp_valid <= '0;

      // A REQ while busy is dropped; the host must retry once BUSY falls.
      for (int i = 0; i < 2; i++) begin
        if (req_in[i] && !busy[i]) begin
          pend[i]     <= 1'b1;
          host_cmd[i] <= in_cmd[i];
        end
      end

      case (state)
        S_IDLE: begin
          // Release uses the registered lock state, so the other host is
          // granted on the following edge at the earliest.
          if (lock_valid && !lock_in[lock_owner] && !pend[lock_owner])
            lock_valid <= 1'b0;
          if (|elig) begin
            core_cmd   <= host_cmd[grant_host];
            cur        <= grant_host;
            last_grant <= grant_host;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!iCORE_BUSY) begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (iCORE_VALID || timeout_hit) begin
            rsp_valid[cur] <= 1'b1;
            rsp_error[cur] <= iCORE_VALID ? iCORE_ERROR : 1'b1;
            rsp_data[cur]  <= iCORE_VALID ? iCORE_DATA : 32'd0;
            pend[cur]      <= 1'b0;
            lock_valid     <= lock_in[cur];
            if (lock_in[cur])
              lock_owner <= cur;
            core_cmd <= '0;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign oCORE_REQ     = (state == S_ISSUE) & ~iCORE_BUSY;
  assign oCORE_COMMAND = core_cmd.command;
  assign oCORE_TARGET  = core_cmd.target;
  assign oCORE_DATA    = core_cmd.data;

  assign oM0_BUSY  = busy[0];
  assign oM1_BUSY  = busy[1];
  assign oM0_VALID = rsp_valid[0];
  assign oM1_VALID = rsp_valid[1];
  assign oM0_ERROR = rsp_error[0];
  assign oM1_ERROR = rsp_error[1];
  assign oM0_DATA  = rsp_data[0];
  assign oM1_DATA  = rsp_data[1];

  assign oLOCK_VALID = lock_valid;
  assign oLOCK_OWNER = lock_owner;

endmodule

// File: tb/tb_processor_debug_cmd_arbiter.sv
module tb_processor_debug_cmd_arbiter;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        req [2];
  logic        lock [2];
  logic [3:0]  cmd [2];
  logic [7:0]  tgt [2];
  logic [31:0] dat [2];
  logic        busy [2];
  logic        vld [2];
  logic        err [2];
  logic [31:0] rdat [2];
  logic        oCORE_REQ, iCORE_BUSY, iCORE_VALID, iCORE_ERROR;
  logic [3:0]  oCORE_COMMAND;
  logic [7:0]  oCORE_TARGET;
  logic [31:0] oCORE_DATA, iCORE_DATA;
  logic        oLOCK_VALID, oLOCK_OWNER;

  int checks = 0;
  int errors = 0;
  // Reference model: last granted host and the command each host has queued.
  int          mlast;
  logic [3:0]  e_cmd [2];
  logic [7:0]  e_tgt [2];
  logic [31:0] e_dat [2];

  always #5 iCLOCK = ~iCLOCK;

  processor_debug_cmd_arbiter #(.P_TIMEOUT(16'd16)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iM0_REQ(req[0]), .oM0_BUSY(busy[0]), .iM0_COMMAND(cmd[0]), .iM0_TARGET(tgt[0]),
    .iM0_DATA(dat[0]), .iM0_LOCK(lock[0]), .oM0_VALID(vld[0]), .oM0_ERROR(err[0]),
    .oM0_DATA(rdat[0]),
    .iM1_REQ(req[1]), .oM1_BUSY(busy[1]), .iM1_COMMAND(cmd[1]), .iM1_TARGET(tgt[1]),
    .iM1_DATA(dat[1]), .iM1_LOCK(lock[1]), .oM1_VALID(vld[1]), .oM1_ERROR(err[1]),
    .oM1_DATA(rdat[1]),
    .oCORE_REQ(oCORE_REQ), .iCORE_BUSY(iCORE_BUSY), .oCORE_COMMAND(oCORE_COMMAND),
    .oCORE_TARGET(oCORE_TARGET), .oCORE_DATA(oCORE_DATA), .iCORE_VALID(iCORE_VALID),
    .iCORE_ERROR(iCORE_ERROR), .iCORE_DATA(iCORE_DATA),
    .oLOCK_VALID(oLOCK_VALID), .oLOCK_OWNER(oLOCK_OWNER)
  );

  task automatic cyc();
    @(posedge iCLOCK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input int h, input logic [3:0] c, input logic [7:0] t,
                            input logic [31:0] d);
    cmd[h] = c; tgt[h] = t; dat[h] = d;
    e_cmd[h] = c; e_tgt[h] = t; e_dat[h] = d;
  endtask

  task automatic pulse(input int h, input logic [3:0] c, input logic [7:0] t,
                       input logic [31:0] d);
    chk("busy_before_req", 32'(busy[h]), 0);
    set_fields(h, c, t, d);
    req[h] = 1'b1;
    cyc();
    req[h] = 1'b0;
  endtask

  task automatic pulse2(input logic [3:0] c0, input logic [7:0] t0, input logic [31:0] d0,
                        input logic [3:0] c1, input logic [7:0] t1, input logic [31:0] d1);
    chk("busy0_before_req", 32'(busy[0]), 0);
    chk("busy1_before_req", 32'(busy[1]), 0);
    set_fields(0, c0, t0, d0);
    set_fields(1, c1, t1, d1);
    req[0] = 1'b1; req[1] = 1'b1;
    cyc();
    req[0] = 1'b0; req[1] = 1'b0;
  endtask

  task automatic wait_core(output int n);
    n = 0;
    while (!oCORE_REQ && n < 40) begin
      cyc();
      n++;
    end
    chk("core_req_seen", 32'(oCORE_REQ), 1);
  endtask

  // Plays the core for one command expected from host h.
  task automatic serve(input int h, input int busy_n, input int dly,
                       input logic [31:0] rd, input logic re, output int lat);
    if (busy_n > 0) begin
      iCORE_BUSY = 1'b1;
      for (int i = 0; i < busy_n; i++) begin
        cyc();
        chk("req_while_core_busy", 32'(oCORE_REQ), 0);
      end
      iCORE_BUSY = 1'b0;
      #1;
    end
    wait_core(lat);
    chk("core_cmd", 32'(oCORE_COMMAND), 32'(e_cmd[h]));
    chk("core_tgt", 32'(oCORE_TARGET), 32'(e_tgt[h]));
    chk("core_dat", oCORE_DATA, e_dat[h]);
    for (int i = 0; i < dly; i++) begin
      cyc();
      chk("single_core_req", 32'(oCORE_REQ), 0);
      chk("core_tgt_held", 32'(oCORE_TARGET), 32'(e_tgt[h]));
    end
    iCORE_VALID = 1'b1; iCORE_DATA = rd; iCORE_ERROR = re;
    cyc();
    iCORE_VALID = 1'b0; iCORE_DATA = '0; iCORE_ERROR = 1'b0;
    chk("rsp_valid", 32'(vld[h]), 1);
    chk("rsp_data", rdat[h], rd);
    chk("rsp_error", 32'(err[h]), 32'(re));
    chk("other_no_valid", 32'(vld[1-h]), 0);
    chk("busy_drops", 32'(busy[h]), 0);
    chk("core_cmd_cleared", oCORE_DATA, 0);
    mlast = h;
  endtask

  initial begin
    int lat, first, n;
    logic [31:0] rd;
    for (int h = 0; h < 2; h++) begin
      req[h] = 0; lock[h] = 0; cmd[h] = 0; tgt[h] = 0; dat[h] = 0;
    end
    iCORE_BUSY = 0; iCORE_VALID = 0; iCORE_ERROR = 0; iCORE_DATA = 0;
    mlast = 1;
    repeat (3) cyc();
    chk("rst_core_req", 32'(oCORE_REQ), 0);
    chk("rst_busy0", 32'(busy[0]), 0);
    chk("rst_busy1", 32'(busy[1]), 0);
    chk("rst_lock", 32'(oLOCK_VALID), 0);
    chk("rst_valid0", 32'(vld[0]), 0);
    chk("rst_data1", rdat[1], 0);
    inRESET = 1'b1;
    cyc();

    // Single M0 register read, response 3 cycles after the core request.
    pulse(0, 4'h0, 8'd67, 32'h0);
    chk("busy_while_pending", 32'(busy[0]), 1);
    serve(0, 0, 3, 32'h0000_1234, 1'b0, lat);
    chk("grant_latency", lat, 1);
    cyc();
    chk("valid_is_pulse", 32'(vld[0]), 0);
    chk("data_held", rdat[0], 32'h0000_1234);

    // Simultaneous requests: model picks the host other than the last one granted.
    for (int r = 0; r < 2; r++) begin
      pulse2(4'h1, 8'h10, 32'h100 + r, 4'h2, 8'h21, 32'h200 + r);
      first = (mlast == 1) ? 0 : 1;
      serve(first, 0, 1, 32'hA000 + r, 1'b0, lat);
      serve(1 - first, 0, 2, 32'hB000 + r, 1'b1, lat);
    end
    pulse(0, 4'h3, 8'h33, 32'h3);
    serve(0, 0, 1, 32'h3333, 1'b0, lat);
    pulse2(4'h4, 8'h40, 32'h4, 4'h5, 8'h51, 32'h5);
    first = (mlast == 1) ? 0 : 1;
    serve(first, 0, 1, 32'h4444, 1'b0, lat);
    serve(1 - first, 0, 1, 32'h5555, 1'b0, lat);

    // Locked sequence: STOP, 37 reads, GO while M1 keeps requesting.
    lock[0] = 1'b1;
    pulse(0, 4'hF, 8'h0, 32'h0);
    serve(0, 0, 2, 32'h1, 1'b0, lat);
    chk("lock_valid", 32'(oLOCK_VALID), 1);
    chk("lock_owner", 32'(oLOCK_OWNER), 0);
    set_fields(1, 4'h6, 8'hAA, 32'h0000_CAFE);
    req[1] = 1'b1;
    for (int k = 0; k < 37; k++) begin
      pulse(0, 4'h0, 8'(k), 32'h0);
      chk("m1_locked_out", 32'(busy[1]), 1);
      serve(0, 0, 1 + (k % 3), 32'h7000 + k, 1'b0, lat);
    end
    pulse(0, 4'h8, 8'h0, 32'h0);
    serve(0, 0, 1, 32'h8, 1'b0, lat);
    chk("lock_kept", 32'(oLOCK_VALID), 1);
    lock[0] = 1'b0;
    cyc();
    chk("lock_released", 32'(oLOCK_VALID), 0);
    chk("m1_unblocked", 32'(busy[1]), 0);
    cyc();
    req[1] = 1'b0;
    chk("m1_latched", 32'(busy[1]), 1);
    serve(1, 0, 1, 32'h5A5A_0001, 1'b0, lat);
    chk("m1_grant_after_unlock", lat, 1);

    // Core busy for 10 cycles before accepting.
    pulse(0, 4'h9, 8'h99, 32'h9);
    serve(0, 10, 2, 32'h9999, 1'b0, lat);
    chk("req_once_not_busy", lat, 0);

    // Timeout: core never answers M1.
    pulse(1, 4'h2, 8'h77, 32'h77);
    wait_core(lat);
    chk("tmo_core_tgt", 32'(oCORE_TARGET), 32'h77);
    cyc();
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("tmo_no_early_valid", 32'(vld[1]), 0);
    end
    cyc();
    chk("tmo_valid", 32'(vld[1]), 1);
    chk("tmo_error", 32'(err[1]), 1);
    chk("tmo_data", rdat[1], 0);
    chk("tmo_busy", 32'(busy[1]), 0);
    mlast = 1;
    repeat (3) cyc();
    iCORE_VALID = 1'b1; iCORE_DATA = 32'hDEAD_BEEF;
    cyc();
    iCORE_VALID = 1'b0; iCORE_DATA = '0;
    chk("late_valid_m0", 32'(vld[0]), 0);
    chk("late_valid_m1", 32'(vld[1]), 0);
    chk("late_data_m1", rdat[1], 0);

    // Reset in the middle of WAIT while M0 holds the lock.
    lock[0] = 1'b1;
    pulse(0, 4'h1, 8'h11, 32'h11);
    serve(0, 0, 1, 32'h1111, 1'b0, lat);
    pulse(0, 4'h1, 8'h12, 32'h12);
    wait_core(lat);
    cyc();
    inRESET = 1'b0;
    #1;
    chk("arst_core_tgt", 32'(oCORE_TARGET), 0);
    chk("arst_lock", 32'(oLOCK_VALID), 0);
    chk("arst_busy0", 32'(busy[0]), 0);
    chk("arst_busy1", 32'(busy[1]), 0);
    chk("arst_data0", rdat[0], 0);
    mlast = 1;
    lock[0] = 1'b0;
    iCORE_VALID = 1'b1;
    cyc();
    iCORE_VALID = 1'b0;
    inRESET = 1'b1;
    cyc();
    chk("no_rsp_after_rst", 32'(vld[0]), 0);
    pulse(1, 4'hC, 8'hC1, 32'hC1);
    serve(1, 0, 2, 32'hC0DE, 1'b0, lat);

    // Randomized traffic checked against the round-robin model.
    for (int r = 0; r < 40; r++) begin
      n = int'($urandom_range(1, 3));
      if (n == 3) begin
        pulse2(4'($urandom), {7'($urandom), 1'b0}, $urandom,
               4'($urandom), {7'($urandom), 1'b1}, $urandom);
        first = (mlast == 1) ? 0 : 1;
      end else begin
        first = n - 1;
        pulse(first, 4'($urandom), 8'($urandom), $urandom);
      end
      rd = $urandom;
      serve(first, int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), rd,
            1'($urandom), lat);
      if (n == 3) begin
        rd = $urandom;
        serve(1 - first, int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), rd,
              1'($urandom), lat);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
